// File: rtl/display_pkg.sv
// display_pkg: segment glyphs (bit 6 = a .. bit 0 = g, active-high),
// display modes and the overflow message helper for display_controlador.
package display_pkg;

  localparam logic [6:0] SEG_0 = 7'b1111110;
  localparam logic [6:0] SEG_1 = 7'b0110000;
  localparam logic [6:0] SEG_2 = 7'b1101101;
  localparam logic [6:0] SEG_3 = 7'b1111001;
  localparam logic [6:0] SEG_4 = 7'b0110011;
  localparam logic [6:0] SEG_5 = 7'b1011011;
  localparam logic [6:0] SEG_6 = 7'b1011111;
  localparam logic [6:0] SEG_7 = 7'b1110000;
  localparam logic [6:0] SEG_8 = 7'b1111111;
  localparam logic [6:0] SEG_9 = 7'b1111011;
  localparam logic [6:0] SEG_A = 7'b1110111;
  localparam logic [6:0] SEG_B = 7'b0011111;
  localparam logic [6:0] SEG_C = 7'b1001110;
  localparam logic [6:0] SEG_D = 7'b0111101;
  localparam logic [6:0] SEG_E = 7'b1001111;
  localparam logic [6:0] SEG_F = 7'b1000111;
  localparam logic [6:0] SEG_U = 7'b0111110;
  localparam logic [6:0] SEG_O = 7'b1111110;

  localparam logic [6:0] SEG_TRACO   = 7'b0000001;
  localparam logic [6:0] SEG_APAGADO = 7'b0000000;
  localparam logic [6:0] SEG_TODOS   = 7'b1111111;

  typedef enum logic [1:0] {
    MODO_DEC   = 2'b00,
    MODO_HEX   = 2'b01,
    MODO_APAGA = 2'b10,
    MODO_TESTE = 2'b11
  } modo_e;

  // "AEUO" read from digit 0 upward; higher digits stay dark.
  function automatic logic [6:0] seg_ovf(input int pos);
    logic [6:0] s;
    case (pos)
      0:       s = SEG_A;
      1:       s = SEG_E;
      2:       s = SEG_U;
      3:       s = SEG_O;
      default: s = SEG_APAGADO;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/decod_7seg.sv
// decod_7seg: nibble + hex flag -> active-high segments a..g (bit 6 = a).
// Ports: nibble (4b), hex (1 = show A..F, 0 = dash for 10..15), seg (7b).
module decod_7seg
  import display_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       hex,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_TRACO;
    case (nibble)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = hex ? SEG_A : SEG_TRACO;
      4'hB: seg = hex ? SEG_B : SEG_TRACO;
      4'hC: seg = hex ? SEG_C : SEG_TRACO;
      4'hD: seg = hex ? SEG_D : SEG_TRACO;
      4'hE: seg = hex ? SEG_E : SEG_TRACO;
      4'hF: seg = hex ? SEG_F : SEG_TRACO;
      default: seg = SEG_TRACO;
    endcase
  end

endmodule

// File: rtl/display_controlador.sv
// display_controlador: registered N-digit 7-segment driver with hex mode,
// leading-zero blanking, lamp test, blinking overflow message and load ack.
// Ports: clock, reset_n (sync), carregar, digitos, controle_displays,
// overflow, apagar_zeros -> displays (7 bits/digit), atualizado (pulse).
module display_controlador
  import display_pkg::*;
#(
  parameter int N_DIGITOS   = 5,
  parameter int BLINK_DIV   = 25_000_000,
  parameter int ATIVO_BAIXO = 1
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   carregar,
  input  logic [4*N_DIGITOS-1:0] digitos,
  input  logic [1:0]             controle_displays,
  input  logic                   overflow,
  input  logic                   apagar_zeros,
  output logic [7*N_DIGITOS-1:0] displays,
  output logic                   atualizado
);

  localparam int CW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(BLINK_DIV - 1);
  localparam logic [7*N_DIGITOS-1:0] DISP_OFF =
    (ATIVO_BAIXO != 0) ? {7*N_DIGITOS{1'b1}} : {7*N_DIGITOS{1'b0}};

  logic [4*N_DIGITOS-1:0] dig_q, dig_d;
  modo_e                  modo_q, modo_d;
  logic                   ovf_q, ovf_d;
  logic                   apaga_q, apaga_d;
  logic                   pend_q, pend_d;
  logic                   atu_q, atu_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   fase_q, fase_d;
  logic [7*N_DIGITOS-1:0] disp_q, disp_d;

  logic                   eh_hex;
  logic [6:0]             seg_dec [N_DIGITOS];
  logic [6:0]             seg;
  logic                   zero_run;
  logic                   blank_lz;

  assign eh_hex = (modo_q == MODO_HEX);

  for (genvar g = 0; g < N_DIGITOS; g++) begin : g_dec
    decod_7seg u_dec (
      .nibble (dig_q[4*g +: 4]),
      .hex    (eh_hex),
      .seg    (seg_dec[g])
    );
  end

  // Latch stage and the two-step acknowledge: pend marks a load just
  // latched, atu fires on the cycle displays first shows it.
  always_comb begin
    dig_d   = dig_q;
    modo_d  = modo_q;
    ovf_d   = ovf_q;
    apaga_d = apaga_q;
    if (carregar) begin
      dig_d   = digitos;
      modo_d  = modo_e'(controle_displays);
      ovf_d   = overflow;
      apaga_d = apagar_zeros;
    end
    pend_d = carregar;
    atu_d  = pend_q;
  end

  // Blink: a fresh overflow restarts with the phase visible, so the
  // message appears on the very first output cycle after the load.
  always_comb begin
    cnt_d  = cnt_q;
    fase_d = fase_q;
    if (ovf_d && !ovf_q) begin
      cnt_d  = '0;
      fase_d = 1'b1;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d  = '0;
      fase_d = !fase_q;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Scan from the top digit; zero_run stays set while every digit
  // above and including i is zero.
  always_comb begin
    disp_d   = '0;
    seg      = SEG_APAGADO;
    zero_run = 1'b1;
    blank_lz = 1'b0;
    for (int i = N_DIGITOS - 1; i >= 0; i--) begin
      zero_run = zero_run && (dig_q[4*i +: 4] == 4'h0);
      blank_lz = apaga_q && zero_run && (i != 0);
      unique case (modo_q)
        MODO_TESTE: seg = SEG_TODOS;
        MODO_APAGA: seg = SEG_APAGADO;
        MODO_DEC, MODO_HEX: begin
          if (ovf_q)
            seg = fase_q ? seg_ovf(i) : SEG_APAGADO;
          else if (blank_lz)
            seg = SEG_APAGADO;
          else
            seg = seg_dec[i];
        end
        default: seg = SEG_APAGADO;
      endcase
      disp_d[7*i +: 7] = (ATIVO_BAIXO != 0) ? ~seg : seg;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      dig_q   <= '0;
      modo_q  <= MODO_APAGA;
      ovf_q   <= 1'b0;
      apaga_q <= 1'b0;
      pend_q  <= 1'b0;
      atu_q   <= 1'b0;
      cnt_q   <= '0;
      fase_q  <= 1'b1;
      disp_q  <= DISP_OFF;
    end else begin
      dig_q   <= dig_d;
      modo_q  <= modo_d;
      ovf_q   <= ovf_d;
      apaga_q <= apaga_d;
      pend_q  <= pend_d;
      atu_q   <= atu_d;
      cnt_q   <= cnt_d;
      fase_q  <= fase_d;
      disp_q  <= disp_d;
    end
  end

  assign displays   = disp_q;
  assign atualizado = atu_q;

endmodule

// File: tb/tb_display_controlador.sv
// tb_display_controlador: table vectors + scoreboard on atualizado,
// hand sequences for blinking, reset and an 8-digit active-high instance.
module tb_display_controlador;

  localparam logic [6:0] G0 = 7'b1111110;
  localparam logic [6:0] G1 = 7'b0110000;
  localparam logic [6:0] G2 = 7'b1101101;
  localparam logic [6:0] G3 = 7'b1111001;
  localparam logic [6:0] G4 = 7'b0110011;
  localparam logic [6:0] G5 = 7'b1011011;
  localparam logic [6:0] G6 = 7'b1011111;
  localparam logic [6:0] G7 = 7'b1110000;
  localparam logic [6:0] G8 = 7'b1111111;
  localparam logic [6:0] G9 = 7'b1111011;
  localparam logic [6:0] GA = 7'b1110111;
  localparam logic [6:0] GB = 7'b0011111;
  localparam logic [6:0] GC = 7'b1001110;
  localparam logic [6:0] GD = 7'b0111101;
  localparam logic [6:0] GE = 7'b1001111;
  localparam logic [6:0] GF = 7'b1000111;
  localparam logic [6:0] GU = 7'b0111110;
  localparam logic [6:0] DS = 7'b0000001;
  localparam logic [6:0] OF = 7'b0000000;

  localparam logic [34:0] ALL_ON  = {35{1'b1}};
  localparam logic [34:0] ALL_OFF = '0;
  localparam logic [34:0] MSG     = {OF, G0, GU, GE, GA};

  typedef struct {
    logic [19:0] d;
    logic [1:0]  m;
    logic        o;
    logic        a;
    logic [34:0] e;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        car;
  logic [19:0] dig;
  logic [1:0]  modo;
  logic        ovf;
  logic        apaga;
  logic [34:0] disp;
  logic        atu;

  logic        car2;
  logic [31:0] dig2;
  logic [1:0]  modo2;
  logic        ovf2;
  logic        apaga2;
  logic [55:0] disp2;
  logic        atu2;

  int          checks   = 0;
  int          failures = 0;
  logic [34:0] sb [$];
  logic [34:0] exp_v;
  vec_t        tab [12];

  always #5 clk = ~clk;

  display_controlador #(
    .N_DIGITOS   (5),
    .BLINK_DIV   (4),
    .ATIVO_BAIXO (1)
  ) dut (
    .clock             (clk),
    .reset_n           (rst_n),
    .carregar          (car),
    .digitos           (dig),
    .controle_displays (modo),
    .overflow          (ovf),
    .apagar_zeros      (apaga),
    .displays          (disp),
    .atualizado        (atu)
  );

  display_controlador #(
    .N_DIGITOS   (8),
    .BLINK_DIV   (4),
    .ATIVO_BAIXO (0)
  ) dut2 (
    .clock             (clk),
    .reset_n           (rst_n),
    .carregar          (car2),
    .digitos           (dig2),
    .controle_displays (modo2),
    .overflow          (ovf2),
    .apagar_zeros      (apaga2),
    .displays          (disp2),
    .atualizado        (atu2)
  );

  // Every atualizado pulse must match the oldest pending load.
  always @(negedge clk) begin
    if (atu === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL atu_spurious got=1 exp=0 disp=%h", disp);
      end else begin
        exp_v = sb.pop_front();
        if (disp !== ~exp_v) begin
          failures++;
          $display("FAIL sb_disp got=%h exp=%h", disp, ~exp_v);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic load(input logic [19:0] d, input logic [1:0] m,
                      input logic o, input logic a,
                      input logic [34:0] e);
    @(negedge clk);
    dig   = d;
    modo  = m;
    ovf   = o;
    apaga = a;
    car   = 1'b1;
    sb.push_back(e);
    @(negedge clk);
    car = 1'b0;
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while (sb.size() != 0 && n < 10) begin
      @(negedge clk);
      #1;
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL %s_timeout got=%0d pending exp=0", nm, sb.size());
      sb.delete();
    end
  endtask

  task automatic blink_chk(input string nm, input int from, input int to);
    for (int j = from; j <= to; j++) begin
      @(negedge clk);
      #1;
      chk(nm, {29'd0, disp}, {29'd0, ~((j % 8 < 4) ? MSG : ALL_OFF)});
    end
  endtask

  initial begin
    tab[0]  = '{20'h12345, 2'd0, 1'b0, 1'b0, {G1, G2, G3, G4, G5}};
    tab[1]  = '{20'h00070, 2'd0, 1'b0, 1'b1, {OF, OF, OF, G7, G0}};
    tab[2]  = '{20'h00000, 2'd0, 1'b0, 1'b1, {OF, OF, OF, OF, G0}};
    tab[3]  = '{20'h0ABCF, 2'd1, 1'b0, 1'b0, {G0, GA, GB, GC, GF}};
    tab[4]  = '{20'h0ABCF, 2'd0, 1'b0, 1'b0, {G0, DS, DS, DS, DS}};
    tab[5]  = '{20'h0ABCF, 2'd0, 1'b0, 1'b1, {OF, DS, DS, DS, DS}};
    tab[6]  = '{20'h0ABCF, 2'd2, 1'b1, 1'b0, ALL_OFF};
    tab[7]  = '{20'h98760, 2'd3, 1'b1, 1'b1, ALL_ON};
    tab[8]  = '{20'h00070, 2'd1, 1'b0, 1'b0, {G0, G0, G0, G7, G0}};
    tab[9]  = '{20'h10000, 2'd0, 1'b0, 1'b1, {G1, G0, G0, G0, G0}};
    tab[10] = '{20'hDE009, 2'd1, 1'b0, 1'b1, {GD, GE, G0, G0, G9}};
    tab[11] = '{20'h00E00, 2'd1, 1'b0, 1'b1, {OF, OF, GE, G0, G0}};

    rst_n = 1'b0;
    car = 1'b0; dig = '0; modo = '0; ovf = 1'b0; apaga = 1'b0;
    car2 = 1'b0; dig2 = '0; modo2 = '0; ovf2 = 1'b0; apaga2 = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_disp", {29'd0, disp}, {29'd0, ALL_ON});
    chk("rst_atu", {63'd0, atu}, 64'd0);
    chk("rst_disp2", {8'd0, disp2}, 64'd0);
    chk("rst_atu2", {63'd0, atu2}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("idle_disp", {29'd0, disp}, {29'd0, ALL_ON});

    for (int i = 0; i < 12; i++) begin
      load(tab[i].d, tab[i].m, tab[i].o, tab[i].a, tab[i].e);
      drain("vec");
      @(negedge clk);
      #1;
      chk("vec_hold", {29'd0, disp}, {29'd0, ~tab[i].e});
    end

    // Back-to-back loads: two acks, last value wins.
    @(negedge clk);
    dig = 20'h12345; modo = 2'd0; ovf = 1'b0; apaga = 1'b0;
    car = 1'b1;
    sb.push_back({G1, G2, G3, G4, G5});
    @(negedge clk);
    dig = 20'h00070; apaga = 1'b1;
    sb.push_back({OF, OF, OF, G7, G0});
    @(negedge clk);
    car = 1'b0;
    drain("b2b");
    repeat (3) @(negedge clk);
    #1;
    chk("b2b_last", {29'd0, disp}, {29'd0, ~{OF, OF, OF, G7, G0}});

    // Overflow blink: 4 cycles on, 4 off.
    load(20'h12345, 2'd0, 1'b1, 1'b0, MSG);
    drain("ovf");
    blink_chk("ovf_blink", 1, 11);

    // Lamp test overrides overflow, no blinking.
    load(20'h12345, 2'd3, 1'b1, 1'b0, ALL_ON);
    drain("lamp");
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      #1;
      chk("lamp_steady", {29'd0, disp}, {29'd0, ~ALL_ON});
    end

    // Reset in the blank phase, together with a load that must be lost.
    load(20'h00009, 2'd0, 1'b0, 1'b1, {OF, OF, OF, OF, G9});
    drain("pre_rst");
    load(20'h00009, 2'd0, 1'b1, 1'b0, MSG);
    drain("ovf2");
    blink_chk("ovf2_blink", 1, 5);
    rst_n = 1'b0;
    car   = 1'b1;
    modo  = 2'd3;
    ovf   = 1'b0;
    @(negedge clk);
    car = 1'b0;
    #1;
    chk("rst_mid_disp", {29'd0, disp}, {29'd0, ALL_ON});
    chk("rst_mid_atu", {63'd0, atu}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      #1;
      chk("rst_after", {29'd0, disp}, {29'd0, ALL_ON});
    end
    load(20'h00009, 2'd0, 1'b1, 1'b0, MSG);
    drain("ovf3");
    blink_chk("ovf3_blink", 1, 4);

    // 8 digits, active-high.
    @(negedge clk);
    dig2  = 32'h87654321;
    modo2 = 2'd0;
    car2  = 1'b1;
    @(negedge clk);
    car2 = 1'b0;
    #1;
    chk("d2_atu_early", {63'd0, atu2}, 64'd0);
    @(negedge clk);
    #1;
    chk("d2_atu", {63'd0, atu2}, 64'd1);
    chk("d2_disp", {8'd0, disp2},
        {8'd0, G8, G7, G6, G5, G4, G3, G2, G1});
    @(negedge clk);
    #1;
    chk("d2_atu_drop", {63'd0, atu2}, 64'd0);
    @(negedge clk);
    modo2 = 2'd2;
    car2  = 1'b1;
    @(negedge clk);
    car2 = 1'b0;
    @(negedge clk);
    #1;
    chk("d2_blank", {8'd0, disp2}, 64'd0);
    chk("d2_blank_atu", {63'd0, atu2}, 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
